// File: rtl/piradip_register_to_stream_mc.sv
// Multi-channel register-to-AXI-Stream bridge: register writes feed per-channel FIFOs.
// Optional build macro PIRADIP_R2S_IRQ_EN enables the registered irq output and irq_en bits.
module piradip_register_to_stream_mc #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned REGISTER_ADDR_BITS = 8,
  parameter int unsigned NUM_CHANNELS       = 2,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter int unsigned BASE_REGNO         = 0
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 wren,
  input  logic [REGISTER_ADDR_BITS-1:0]        wreg_no,
  input  logic [DATA_WIDTH-1:0]                wreg_data,
  input  logic [DATA_WIDTH/8-1:0]              wstrb,
  input  logic                                 rden,
  input  logic [REGISTER_ADDR_BITS-1:0]        rreg_no,
  output logic [DATA_WIDTH-1:0]                rreg_data,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   m_tdata,
  output logic [NUM_CHANNELS-1:0]              m_tvalid,
  output logic [NUM_CHANNELS-1:0]              m_tlast,
  input  logic [NUM_CHANNELS-1:0]              m_tready,
  output logic [NUM_CHANNELS-1:0]              push_ok,
  output logic [NUM_CHANNELS-1:0]              push_fail,
  output logic                                 irq
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_WIDTH + 1;

  logic [EW-1:0] mem_q [NUM_CHANNELS][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [NUM_CHANNELS];
  logic [PW-1:0] wr_ptr_d [NUM_CHANNELS];
  logic [PW-1:0] rd_ptr_q [NUM_CHANNELS];
  logic [PW-1:0] rd_ptr_d [NUM_CHANNELS];
  logic [LW-1:0] level_q  [NUM_CHANNELS];
  logic [LW-1:0] level_d  [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] ovf_q, ovf_d, irq_en_q, irq_en_d;
  logic [NUM_CHANNELS-1:0] push_ok_q, push_fail_q;
  logic [NUM_CHANNELS-1:0] empty, full, pop, push_req, push_last, flush, clr;
  logic [NUM_CHANNELS-1:0] accept, fail, empty_d;
  logic [DATA_WIDTH-1:0]   push_data;

  function automatic logic hit(logic [REGISTER_ADDR_BITS-1:0] a, int unsigned c,
                               int unsigned k);
    return a == REGISTER_ADDR_BITS'(BASE_REGNO + 4 * c + k);
  endfunction

  // Byte lanes without a strobe are pushed as zero.
  always_comb begin
    push_data = '0;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      if (wstrb[b]) push_data[8*b +: 8] = wreg_data[8*b +: 8];
    end
  end

  always_comb begin
    empty     = '0;
    full      = '0;
    pop       = '0;
    push_req  = '0;
    push_last = '0;
    flush     = '0;
    clr       = '0;
    accept    = '0;
    fail      = '0;
    empty_d   = '0;
    ovf_d     = '0;
    irq_en_d  = irq_en_q;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      wr_ptr_d[c]  = wr_ptr_q[c];
      rd_ptr_d[c]  = rd_ptr_q[c];
      level_d[c]   = level_q[c];
      empty[c]     = (level_q[c] == '0);
      full[c]      = (level_q[c] == LW'(FIFO_DEPTH));
      pop[c]       = ~empty[c] & m_tready[c];
      push_last[c] = hit(wreg_no, c, 1);
      push_req[c]  = wren & (hit(wreg_no, c, 0) | push_last[c]);
      flush[c]     = wren & hit(wreg_no, c, 2) & wstrb[3] & wreg_data[31];
      clr[c]       = rden & hit(rreg_no, c, 2);
      accept[c]    = push_req[c] & (~full[c] | pop[c]);
      fail[c]      = push_req[c] & ~accept[c];
      if (flush[c]) begin
        // Flush wins over a concurrent pop; push cannot coincide (one write per cycle).
        rd_ptr_d[c] = wr_ptr_q[c];
        level_d[c]  = '0;
      end else begin
        wr_ptr_d[c] = wr_ptr_q[c] + PW'(accept[c]);
        rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop[c]);
        level_d[c]  = level_q[c] + LW'(accept[c]) - LW'(pop[c]);
      end
      empty_d[c] = (level_d[c] == '0);
      // A failed push outranks a clearing read in the same cycle.
      ovf_d[c]   = fail[c] | (ovf_q[c] & ~clr[c]);
`ifdef PIRADIP_R2S_IRQ_EN
      if (wren && hit(wreg_no, c, 2) && wstrb[0]) irq_en_d[c] = wreg_data[3];
`else
      irq_en_d[c] = 1'b0;
`endif
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        level_q[c]  <= '0;
      end
      ovf_q       <= '0;
      irq_en_q    <= '0;
      push_ok_q   <= '0;
      push_fail_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        level_q[c]  <= level_d[c];
      end
      ovf_q       <= ovf_d;
      irq_en_q    <= irq_en_d;
      push_ok_q   <= accept;
      push_fail_q <= fail;
    end
  end

  // Storage needs no reset: outputs are masked while a channel is empty.
  always_ff @(posedge aclk) begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (accept[c]) mem_q[c][wr_ptr_q[c]] <= {push_last[c], push_data};
    end
  end

  always_comb begin
    m_tdata  = '0;
    m_tvalid = '0;
    m_tlast  = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      m_tvalid[c] = ~empty[c];
      if (!empty[c]) begin
        m_tdata[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[c][rd_ptr_q[c]][DATA_WIDTH-1:0];
        m_tlast[c] = mem_q[c][rd_ptr_q[c]][DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rreg_data = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (hit(rreg_no, c, 2)) begin
        rreg_data[0]      = ~full[c];
        rreg_data[1]      = empty[c];
        rreg_data[2]      = ovf_q[c];
        rreg_data[3]      = irq_en_q[c];
        rreg_data[8 +: LW] = level_q[c];
      end
    end
  end

  assign push_ok   = push_ok_q;
  assign push_fail = push_fail_q;

`ifdef PIRADIP_R2S_IRQ_EN
  logic irq_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) irq_q <= 1'b0;
    else          irq_q <= |((irq_en_d & empty_d) | ovf_d);
  end

  assign irq = irq_q;
`else
  logic unused_empty_d;
  assign unused_empty_d = ^empty_d;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_piradip_register_to_stream_mc.sv
// Self-checking bench for piradip_register_to_stream_mc: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_piradip_register_to_stream_mc;

  localparam int DEPTH = 4;
  localparam int NCH   = 2;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        wren;
  logic [7:0]  wreg_no;
  logic [31:0] wreg_data;
  logic [3:0]  wstrb;
  logic        rden;
  logic [7:0]  rreg_no;
  logic [31:0] rreg_data;
  logic [63:0] m_tdata;
  logic [1:0]  m_tvalid, m_tlast, m_tready, push_ok, push_fail;
  logic        irq;

  piradip_register_to_stream_mc #(
    .DATA_WIDTH(32), .REGISTER_ADDR_BITS(8), .NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH),
    .BASE_REGNO(0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .wren(wren), .wreg_no(wreg_no), .wreg_data(wreg_data),
    .wstrb(wstrb), .rden(rden), .rreg_no(rreg_no), .rreg_data(rreg_data), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready), .push_ok(push_ok),
    .push_fail(push_fail), .irq(irq)
  );

  always #5 aclk = ~aclk;

  typedef logic [32:0] ent_t;
  ent_t     mq [NCH][$];
  bit       ovf_m [NCH];
  bit       irqen_m [NCH];
  bit [1:0] exp_ok, exp_fail;
  int       checks = 0;
  int       failures = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_status(int c);
    logic [31:0] r;
    int lvl;
    lvl  = mq[c].size();
    r    = 32'(lvl) << 8;
    r[0] = (lvl != DEPTH);
    r[1] = (lvl == 0);
    r[2] = ovf_m[c];
    r[3] = irqen_m[c];
    return r;
  endfunction

  function automatic logic [31:0] exp_rdata();
    for (int c = 0; c < NCH; c++) if (int'(rreg_no) == 4 * c + 2) return exp_status(c);
    return 32'h0;
  endfunction

  function automatic logic exp_irq();
    logic r;
    r = 1'b0;
`ifdef PIRADIP_R2S_IRQ_EN
    for (int c = 0; c < NCH; c++) r |= (irqen_m[c] && mq[c].size() == 0) || ovf_m[c];
`endif
    return r;
  endfunction

  function automatic logic [31:0] masked(logic [31:0] d, logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  // Check comb outputs, advance the model by one edge, then check registered outputs.
  task automatic step();
    ent_t h;
    bit   pop, push, flush, clr, acc, fail, full;
    #1;
    for (int c = 0; c < NCH; c++) begin
      h = (mq[c].size() > 0) ? mq[c][0] : 33'h0;
      chk($sformatf("tvalid%0d", c), 64'(m_tvalid[c]), 64'(mq[c].size() > 0));
      chk($sformatf("tdata%0d", c), 64'(m_tdata[32*c +: 32]), 64'(h[31:0]));
      chk($sformatf("tlast%0d", c), 64'(m_tlast[c]), 64'(h[32]));
    end
    chk("rreg_data", 64'(rreg_data), 64'(exp_rdata()));
    for (int c = 0; c < NCH; c++) begin
      pop   = (mq[c].size() > 0) && m_tready[c];
      push  = wren && (int'(wreg_no) == 4 * c || int'(wreg_no) == 4 * c + 1);
      flush = wren && int'(wreg_no) == 4 * c + 2 && wstrb[3] && wreg_data[31];
      clr   = rden && int'(rreg_no) == 4 * c + 2;
      full  = (mq[c].size() == DEPTH);
      acc   = push && (!full || pop);
      fail  = push && !acc;
      if (flush) mq[c].delete();
      else begin
        if (pop) void'(mq[c].pop_front());
        if (acc) mq[c].push_back({int'(wreg_no) == 4 * c + 1, masked(wreg_data, wstrb)});
      end
      ovf_m[c] = fail || (ovf_m[c] && !clr);
`ifdef PIRADIP_R2S_IRQ_EN
      if (wren && int'(wreg_no) == 4 * c + 2 && wstrb[0]) irqen_m[c] = wreg_data[3];
`endif
      exp_ok[c]   = acc;
      exp_fail[c] = fail;
    end
    @(posedge aclk);
    #1;
    chk("push_ok", 64'(push_ok), 64'(exp_ok));
    chk("push_fail", 64'(push_fail), 64'(exp_fail));
    chk("irq", 64'(irq), 64'(exp_irq()));
    @(negedge aclk);
  endtask

  task automatic wr(int r, logic [31:0] d, logic [3:0] s);
    wren = 1'b1; wreg_no = 8'(r); wreg_data = d; wstrb = s;
    step();
    wren = 1'b0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete(); ovf_m[c] = 1'b0; irqen_m[c] = 1'b0;
    end
  endtask

  initial begin
    aresetn = 1'b0; wren = 1'b0; wreg_no = 8'h0; wreg_data = 32'h0; wstrb = 4'h0;
    rden = 1'b0; rreg_no = 8'h0; m_tready = 2'b00;
    model_reset();
    #12;
    chk("rst_tvalid", 64'(m_tvalid), 64'h0);
    chk("rst_tdata", m_tdata, 64'h0);
    chk("rst_pulses", 64'({push_ok, push_fail, m_tlast}), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    step();

    // Single push into channel 0.
    wr(0, 32'hDEADBEEF, 4'hF);
    rreg_no = 8'd2;
    #1 chk("single_status", 64'(rreg_data), 64'h101);
    chk("single_tdata", 64'(m_tdata[31:0]), 64'hDEADBEEF);
    step();

    // Overflow on channel 1 and clear-on-read.
    for (int i = 0; i < 5; i++) wr(4, $urandom, 4'($urandom));
    rden = 1'b1; rreg_no = 8'd6;
    #1 chk("ovf_status", 64'(rreg_data), 64'h404);
    step();
    chk("ovf_cleared", 64'(rreg_data), 64'h400);
    step();
    rden = 1'b0;

    // Full FIFO with a pop in the cycle of a DATA_LAST write.
    m_tready = 2'b10;
    wr(5, 32'hCAFE0001, 4'hF);
    for (int i = 0; i < 5; i++) step();
    m_tready = 2'b00;

    // Flush with a concurrent pop.
    wr(0, 32'h11112222, 4'hF);
    wr(0, 32'h33334444, 4'h5);
    m_tready = 2'b01;
    wr(2, 32'h80000000, 4'hF);
    chk("flush_tvalid", 64'(m_tvalid[0]), 64'h0);
    for (int i = 0; i < 3; i++) step();

    // Asynchronous reset while both channels stream.
    m_tready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      wr(i == 2 ? 1 : 0, $urandom, 4'hF);
      wr(i == 2 ? 5 : 4, $urandom, 4'hF);
    end
    m_tready = 2'b11;
    step();
    #2 aresetn = 1'b0;
    #1 chk("arst_tvalid", 64'(m_tvalid), 64'h0);
    chk("arst_tdata", m_tdata, 64'h0);
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    m_tready = 2'b00;
    rreg_no = 8'd2;
    #1 chk("arst_status0", 64'(rreg_data), 64'h3);
    rreg_no = 8'd6;
    #1 chk("arst_status1", 64'(rreg_data), 64'h3);
    step();

    // irq enable on an empty channel, then a push clears the condition.
    wr(2, 32'h00000008, 4'h1);
    wr(0, 32'h0BADF00D, 4'hF);
    m_tready = 2'b01;
    step();
    wr(2, 32'h00000000, 4'h1);

    // Random traffic, including out-of-window register numbers.
    for (int i = 0; i < 400; i++) begin
      wren      = ($urandom_range(0, 2) != 0);
      wreg_no   = 8'($urandom_range(0, 9));
      wreg_data = $urandom;
      wstrb     = 4'($urandom);
      rden      = ($urandom_range(0, 3) == 0);
      rreg_no   = 8'($urandom_range(0, 9));
      m_tready  = 2'($urandom);
      step();
    end
    wren = 1'b0; rden = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
